// File: rtl/divide_operator_seq_pkg.sv
// Shared types for the sequential restoring divider: FSM encoding and counter sizing.
package divide_operator_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 2n (one iteration per dividend bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/divide_operator_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module divide_operator_seq_div_step
  import divide_operator_seq_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic [n:0]   rem_i,
  input  logic [n-1:0] div_i,
  input  logic         bit_i,
  output logic [n:0]   rem_o,
  output logic         qbit_o
);

  logic [n:0] shifted;
  logic       unused_msb;

  // The incoming remainder is always < divisor, so its MSB is zero and drops out of the shift.
  assign unused_msb = rem_i[n];

  always_comb begin
    shifted = {rem_i[n-1:0], bit_i};
    qbit_o  = (shifted >= {1'b0, div_i});
    rem_o   = qbit_o ? (shifted - {1'b0, div_i}) : shifted;
  end

endmodule

// File: rtl/divide_operator_seq.sv
// Sequential restoring divider: 2n-bit dividend / n-bit divisor, one quotient bit per clock.
module divide_operator_seq
  import divide_operator_seq_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*n-1:0] Z,
  input  logic [n-1:0]   B,
  output logic [2*n-1:0] Q,
  output logic [n-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  localparam int unsigned ZW = 2 * n;
  localparam int unsigned CW = cnt_width(n);

  state_e         state_q, state_d;
  logic [ZW-1:0]  dvd_q, dvd_d;
  logic [ZW-1:0]  quo_q, quo_d;
  logic [ZW-1:0]  q_q, q_d;
  logic [n-1:0]   b_q, b_d;
  logic [n-1:0]   r_q, r_d;
  logic [n:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [n:0]     step_rem;
  logic           step_bit;
  logic [ZW-1:0]  quo_shift;

  divide_operator_seq_div_step #(.n(n)) u_step (
    .rem_i  (rem_q),
    .div_i  (b_q),
    .bit_i  (dvd_q[ZW-1]),
    .rem_o  (step_rem),
    .qbit_o (step_bit)
  );

  assign quo_shift = {quo_q[ZW-2:0], step_bit};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = Z;
          b_d   = B;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CW'(ZW);
          if (B != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        dvd_d = {dvd_q[ZW-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = quo_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_shift;
          r_d     = step_rem[n-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        // Divide-by-zero arrives here with done low; publish its result one cycle later.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          q_d    = '1;
          r_d    = dvd_q[n-1:0];
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/divide_operator_seq.md
Name: divide_operator_seq

Overview:
- Sequential restoring divider, the inverse operation of the team's combinational `multiplyOperator` (Z = A*B).
- Takes a 2n-bit product-width dividend Z and an n-bit divisor B, and returns a 2n-bit quotient Q and an n-bit remainder R.
- Produces one quotient bit per clock, using a start/busy/done handshake.
- Used to check multiplier results in-system (Z / B must return A with R = 0) and as the general divide unit next to the multiplier.

Parameters:
- n, 4, operand width: divisor and remainder are n bits; dividend and quotient are 2n bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- Z  input  2n  dividend; captured on the accepting edge
- B  input  n  divisor; captured on the accepting edge
- Q  output  2n  quotient, registered
- R  output  n  remainder, registered
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; Q, R and div_by_zero are valid from this cycle
- div_by_zero  output  1  registered; set when the captured B was 0

Behaviour:
- Reset: the clk edge with rst=1 forces state=IDLE and Q=0, R=0, busy=0, done=0, div_by_zero=0, counter=0. rst has priority over everything, including mid-operation; a division in flight is abandoned and produces no done.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, capture Z into the dividend shift register, capture B, clear the partial remainder (n+1 bits) and set counter=2n.
  - If B != 0: go to RUN, busy=1.
  - If B == 0: go to DONE directly.
- RUN: each edge performs one iteration, then decrements the counter.
  - Iteration: shift the MSB of the dividend register into the LSB of the partial remainder. If the partial remainder >= B, subtract B and shift 1 into the quotient; otherwise shift 0.
  - Comparison and subtraction use n+1 bits so nothing overflows.
  - After the iteration where counter reaches 0: load Q and R (low n bits of the partial remainder), go to DONE, busy=0.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - Q, R and div_by_zero hold until the next accepted start or reset.
- Latency, nonzero divisor: done is high during the cycle after edge t0+2n, where t0 is the accepting edge (8 cycles for n=4). busy is high after edges t0 through t0+2n-1.
- Latency, divide by zero: done is high after edge t0+1. Outputs are Q = all ones, R = Z[n-1:0], div_by_zero=1.
- A nonzero division clears div_by_zero when it completes.
- start while busy=1 or in DONE: ignored; operands are not re-captured.
- start held high continuously: a new division is accepted on the first IDLE edge after done.
- Z and B may change freely after capture; results depend only on the captured values.
- Quotients are never truncated: the full 2n-bit quotient is available (for example, Z/1 = Z).
- Unsigned arithmetic only.

Decomposition:
- Shared include file (div_defs.vh): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, and a counter-width localparam of $clog2(2n)+1.
- One natural sub-module: div_step (combinational). Inputs are the partial remainder (n+1), divisor (n) and incoming bit. Outputs are the next partial remainder and the quotient bit.
- The FSM, counter and registers stay in the top module.

Test Plan:
- n=4, Z=8'h4B, B=4'h5, start pulse → Q=8'h0F, R=4'h0, done after exactly 8 cycles, busy high for 8 cycles, div_by_zero=0.
- Z=8'hB4, B=4'hF → Q=8'h0C, R=0. Then Z=8'hB5, B=4'hF → Q=8'h0C, R=4'h1. Results persist until the next start.
- Z=8'h24, B=4'h0 → done after 1 cycle, Q=8'hFF, R=4'h4, div_by_zero=1. A following Z=8'h10, B=4'h2 → Q=8'h08, R=0, div_by_zero=0.
- Z=8'hFF, B=4'h1 → Q=8'hFF, R=0. Z=8'h00, B=4'h7 → Q=0, R=0.
- During a busy division of 8'h4B/5, pulse start with Z=8'h10, B=4'h2 at cycle 3 → ignored; result still Q=8'h0F, R=0.
- Assert rst at cycle 4 of a division → the next cycle shows all outputs 0 and state IDLE, and no done pulse. A fresh start then computes normally.
- Exhaustive sweep for n=4 (all Z, B) against Z/B and Z%B.
